// File: rtl/esop_tt_sweeper_pkg.sv
// Shared types and sizing for the ESOP truth-table sweeper.
package esop_bench_pkg;

  localparam int N_IN    = 8;
  localparam int WORD_W  = 32;
  localparam int N_PAT   = 1 << N_IN;
  localparam int N_WORDS = N_PAT / WORD_W;
  localparam int BIT_W   = $clog2(WORD_W);
  localparam int IDX_W   = ((N_IN - BIT_W) > 1) ? (N_IN - BIT_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    EMIT  = 2'd3
  } state_t;

  // One in-flight pattern: en marks a real sample, bit_idx is its slot in the word.
  typedef struct packed {
    logic             en;
    logic [BIT_W-1:0] bit_idx;
  } lat_ent_t;

endpackage

// File: rtl/esop_tt_sweeper_if.sv
// Truth-table word stream: valid/ready with data, word index and last flag.
interface esop_tt_sweeper_if;
  import esop_bench_pkg::*;

  logic              tt_valid;
  logic              tt_ready;
  logic [WORD_W-1:0] tt_data;
  logic [IDX_W-1:0]  tt_index;
  logic              tt_last;

  modport master (output tt_valid, tt_data, tt_index, tt_last, input tt_ready);
  modport slave  (input tt_valid, tt_data, tt_index, tt_last, output tt_ready);
endinterface

// File: rtl/esop_tt_sweeper_lat_pipe.sv
// Delay line that tracks each applied pattern until the network's output for it is valid.
module esop_lat_pipe
  import esop_bench_pkg::*;
#(
  parameter int DUT_LAT = 0
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  lat_ent_t i_ent,
  output lat_ent_t o_ent
);

  generate
    if (DUT_LAT == 0) begin : g_pass
      // Combinational network: the sample belongs to the pattern driven this cycle.
      logic w_unused;
      assign w_unused = i_clk ^ i_rst;
      assign o_ent    = i_ent;
    end else begin : g_pipe
      lat_ent_t r_stg [DUT_LAT];

      // Shift entries one stage per cycle; reset empties the line.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < DUT_LAT; i++) r_stg[i] <= '0;
        end else begin
          r_stg[0] <= i_ent;
          for (int i = 1; i < DUT_LAT; i++) r_stg[i] <= r_stg[i-1];
        end
      end

      assign o_ent = r_stg[DUT_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/esop_tt_sweeper.sv
// Exhaustive sweeper: drives every input pattern into an ESOP network, packs the
// sampled outputs into truth-table words and streams them out.
//
// state | meaning
// IDLE  | waiting for start, x_out parked at 0
// DRIVE | applying WORD_W consecutive patterns of the current word
// DRAIN | waiting DUT_LAT cycles for the last samples to return
// EMIT  | presenting the packed word until the consumer takes it
module esop_tt_sweeper
  import esop_bench_pkg::*;
#(
  parameter int DUT_LAT = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [N_IN-1:0]        o_x_out,
  input  logic                   i_y_in,
  esop_tt_sweeper_if.master      tt,
  output logic [N_IN:0]          o_onset
);

  localparam int DRN_W = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
  localparam logic [DRN_W-1:0] DRN_INIT = (DUT_LAT > 0) ? DRN_W'(DUT_LAT - 1) : '0;

  state_t            r_state, w_state_nxt;
  logic [N_IN:0]     r_pat;
  logic [BIT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_k;
  logic [WORD_W-1:0] r_buf;
  logic [N_IN:0]     r_onset;
  logic              r_done;
  logic [DRN_W-1:0]  r_drn;
  lat_ent_t          w_ent_in, w_ent_out;
  logic              w_last_pat, w_last_word, w_unused;

  assign w_last_pat  = (r_cnt == BIT_W'(WORD_W - 1));
  assign w_last_word = (r_k == IDX_W'(N_WORDS - 1));
  assign w_ent_in    = '{en: (r_state == DRIVE), bit_idx: r_cnt};
  // The pattern counter never exceeds N_PAT-1 during a sweep; its top bit is headroom.
  assign w_unused    = r_pat[N_IN];

  esop_lat_pipe #(.DUT_LAT(DUT_LAT)) u_lat_pipe (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_ent (w_ent_in),
    .o_ent (w_ent_out)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; EMIT holds until the handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (i_start) w_state_nxt = DRIVE;
      DRIVE: if (w_last_pat) w_state_nxt = (DUT_LAT == 0) ? EMIT : DRAIN;
      DRAIN: if (r_drn == '0) w_state_nxt = EMIT;
      EMIT:  if (tt.tt_ready) w_state_nxt = w_last_word ? IDLE : DRIVE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pattern counter, word packer, onset counter and done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pat   <= '0;
      r_cnt   <= '0;
      r_k     <= '0;
      r_buf   <= '0;
      r_onset <= '0;
      r_done  <= 1'b0;
      r_drn   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_ent_out.en) begin
        r_buf[w_ent_out.bit_idx] <= i_y_in;
        if (i_y_in && (r_onset != (N_IN+1)'(N_PAT))) r_onset <= r_onset + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_pat   <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
            r_onset <= '0;
          end
        end
        DRIVE: begin
          r_cnt <= r_cnt + 1'b1;
          r_drn <= DRN_INIT;
          // x_out holds the word's last pattern through DRAIN and EMIT.
          if (!w_last_pat) r_pat <= r_pat + 1'b1;
        end
        DRAIN: begin
          if (r_drn != '0) r_drn <= r_drn - 1'b1;
        end
        EMIT: begin
          if (tt.tt_ready) begin
            if (w_last_word) begin
              r_done <= 1'b1;
              r_pat  <= '0;
            end else begin
              r_k   <= r_k + 1'b1;
              r_pat <= r_pat + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_x_out     = r_pat[N_IN-1:0];
  assign o_onset     = r_onset;
  assign tt.tt_valid = (r_state == EMIT);
  assign tt.tt_data  = r_buf;
  assign tt.tt_index = r_k;
  assign tt.tt_last  = (r_state == EMIT) && w_last_word;

endmodule

// File: tb/tb_esop_tt_sweeper.sv
// Scoreboard bench: one sweeper against a combinational network, one against a
// two-cycle registered network.
module tb_esop_tt_sweeper;
  import esop_bench_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start0, start2;
  logic       busy0, done0, busy2, done2;
  logic [7:0] x0, x2;
  logic       y0, y2;
  logic [8:0] on0, on2;
  logic [1:0] mode;
  logic       d1, d2;

  exp_t q0[$];
  exp_t q2[$];
  int   n_chk = 0, n_pass = 0;
  int   pops0 = 0, pops2 = 0, dones0 = 0, dones2 = 0;
  bit   stall_en = 1'b0;
  int   stall_cnt = 0;

  always #5 clk = ~clk;

  esop_tt_sweeper_if if0 ();
  esop_tt_sweeper_if if2 ();

  esop_tt_sweeper #(.DUT_LAT(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .o_busy(busy0), .o_done(done0),
    .o_x_out(x0), .i_y_in(y0), .tt(if0), .o_onset(on0)
  );

  esop_tt_sweeper #(.DUT_LAT(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .o_busy(busy2), .o_done(done2),
    .o_x_out(x2), .i_y_in(y2), .tt(if2), .o_onset(on2)
  );

  // Networks under test: mode 0 -> x0&x1, 1 -> const 0, 2 -> const 1; second one y=x7 after 2 regs.
  assign y0 = (mode == 2'd0) ? (x0[0] & x0[1]) : (mode == 2'd1) ? 1'b0 : 1'b1;
  always @(posedge clk) begin
    d1 <= x2[7];
    d2 <= d1;
  end
  assign y2 = d2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (if0.tt_valid && if0.tt_ready) begin
      pops0++;
      check("dut0 word expected", 64'(q0.size() > 0), 64'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("dut0 data", 64'(if0.tt_data), 64'(e.data));
        check("dut0 index", 64'(if0.tt_index), 64'(e.idx));
        check("dut0 last", 64'(if0.tt_last), 64'(e.last));
      end
    end
    if (if2.tt_valid && if2.tt_ready) begin
      pops2++;
      check("dut2 word expected", 64'(q2.size() > 0), 64'd1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("dut2 data", 64'(if2.tt_data), 64'(e.data));
        check("dut2 index", 64'(if2.tt_index), 64'(e.idx));
        check("dut2 last", 64'(if2.tt_last), 64'(e.last));
      end
    end
    if (done0) begin
      dones0++;
      check("dut0 busy low with done", 64'(busy0), 64'd0);
    end
    if (done2) begin
      dones2++;
      check("dut2 busy low with done", 64'(busy2), 64'd0);
    end
  end

  // Consumer ready for dut0, with an optional 5-cycle stall on word 3.
  initial begin
    if0.tt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en && if0.tt_valid && (if0.tt_index == 3'd3) && (stall_cnt < 5)) begin
        if0.tt_ready = 1'b0;
        stall_cnt++;
        check("stall data held", 64'(if0.tt_data), 64'h8888_8888);
        check("stall x_out frozen", 64'(x0), 64'd127);
      end else begin
        if0.tt_ready = 1'b1;
      end
    end
  end

  task automatic push0(input logic [31:0] w);
    for (int k = 0; k < 8; k++) q0.push_back(exp_t'{data: w, idx: 3'(k), last: (k == 7)});
  endtask

  task automatic pulse0();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask

  task automatic run0(input string name, input logic [1:0] m, input logic [31:0] w,
                      input logic [8:0] exp_on, input bit extra_start);
    int d, p, c;
    mode = m;
    push0(w);
    d = dones0;
    p = pops0;
    pulse0();
    if (extra_start) begin
      repeat (10) @(posedge clk);
      pulse0();
    end
    c = 0;
    while (dones0 == d && c < 3000) begin
      @(posedge clk);
      c++;
    end
    check({name, " done seen"}, 64'(dones0 != d), 64'd1);
    @(posedge clk); #1;
    check({name, " onset"}, 64'(on0), 64'(exp_on));
    check({name, " busy after"}, 64'(busy0), 64'd0);
    check({name, " x_out after"}, 64'(x0), 64'd0);
    check({name, " word count"}, 64'(pops0 - p), 64'd8);
    check({name, " queue drained"}, 64'(q0.size()), 64'd0);
    repeat (40) @(posedge clk); #1;
    check({name, " single done"}, 64'(dones0 - d), 64'd1);
    check({name, " onset held"}, 64'(on0), 64'(exp_on));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d, p, c;
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; mode = 2'd0;
    if2.tt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy0", 64'(busy0), 64'd0);
    check("reset valid0", 64'(if0.tt_valid), 64'd0);
    check("reset x_out0", 64'(x0), 64'd0);
    check("reset onset0", 64'(on0), 64'd0);
    check("reset done0", 64'(done0), 64'd0);
    check("reset data0", 64'(if0.tt_data), 64'd0);
    check("reset valid2", 64'(if2.tt_valid), 64'd0);
    check("reset busy2", 64'(busy2), 64'd0);
    rst = 1'b0;

    run0("and", 2'd0, 32'h8888_8888, 9'd64, 1'b0);
    run0("zero", 2'd1, 32'h0000_0000, 9'd0, 1'b0);
    run0("one", 2'd2, 32'hFFFF_FFFF, 9'd256, 1'b0);

    // Registered network with two cycles of latency.
    for (int k = 0; k < 8; k++)
      q2.push_back(exp_t'{data: (k < 4) ? 32'h0 : 32'hFFFF_FFFF, idx: 3'(k), last: (k == 7)});
    d = dones2;
    p = pops2;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    c = 0;
    while (dones2 == d && c < 3000) begin
      @(posedge clk);
      c++;
    end
    check("lat2 done seen", 64'(dones2 != d), 64'd1);
    @(posedge clk); #1;
    check("lat2 onset", 64'(on2), 64'd128);
    check("lat2 word count", 64'(pops2 - p), 64'd8);
    check("lat2 x_out after", 64'(x2), 64'd0);

    // Backpressure on word 3.
    stall_cnt = 0;
    stall_en = 1'b1;
    run0("stall", 2'd0, 32'h8888_8888, 9'd64, 1'b0);
    stall_en = 1'b0;
    check("stall cycles", 64'(stall_cnt), 64'd5);

    // Reset in the middle of word 2.
    mode = 2'd0;
    push0(32'h8888_8888);
    p = pops0;
    d = dones0;
    pulse0();
    c = 0;
    while (pops0 < p + 2 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    check("rst two words seen", 64'(pops0 - p), 64'd2);
    repeat (5) @(posedge clk);
    #1;
    check("rst pre busy", 64'(busy0), 64'd1);
    check("rst pre index", 64'(if0.tt_index), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst busy", 64'(busy0), 64'd0);
    check("rst valid", 64'(if0.tt_valid), 64'd0);
    check("rst x_out", 64'(x0), 64'd0);
    check("rst onset", 64'(on0), 64'd0);
    q0.delete();
    repeat (40) @(posedge clk); #1;
    check("rst no done", 64'(dones0 - d), 64'd0);
    check("rst stays idle", 64'(busy0), 64'd0);
    run0("after rst", 2'd0, 32'h8888_8888, 9'd64, 1'b0);

    // Start pulsed while busy is ignored.
    run0("restart ignored", 2'd0, 32'h8888_8888, 9'd64, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
